id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- Receiving end of the `if_id_ex` interface: the ID/EX pipeline register between the `id` stage and EX in the RV32 5-stage core.
- Captures the decoded control/data bundle each cycle.
- Inserts bubbles for load-use and JALR-source hazards and drives the ID/IF hold signal.
- Honours downstream freeze (`mem_stall`) and EX redirect flush, and counts inserted bubbles.

Parameters:
XLEN, 32, datapath width (pc, imm, counter)
BRANCH_NONE, 3'd0, `branch` encoding for "no branch/jump"; used in bubbles

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
if_id_ex_ex  input  modport if_id_ex.in  decoded bundle from ID: alu_sela[2], alu_selb[2], mem_opt[3], mem_signed, reg_wr, reg_anum[5], reg_bnum[5], reg_wnum[5], mem_load, ALUctr[3], ALUext, mem_wr, imm[XLEN], branch[3], pc[XLEN]
id_valid  input  1  ID holds a valid instruction
pcg_isjalr  input  1  instruction in ID is JALR (PC gen needs rs1 = reg_anum)
mem_stall  input  1  downstream freeze request
ex_redirect  input  1  EX resolved taken branch/jump; younger instructions are wrong-path
ex_valid  output  1  EX slot holds a real instruction
ex_<field>  output  per field  registered copy of every bundle field above (same names, ex_ prefix)
stall_id  output  1  combinational; IF and ID must hold this cycle
bubble_cnt  output  XLEN  count of hazard bubbles inserted, wraps modulo 2^XLEN

Behaviour:
- Reset (`rst`=1 at posedge): all `ex_*` = 0, `ex_valid` = 0, `ex_branch` = BRANCH_NONE, FSM = RUN, `bubble_cnt` = 0. `stall_id` = 0 while `rst` is high.
- Bubble write: `ex_valid`=0, `ex_reg_wr`=0, `ex_mem_wr`=0, `ex_mem_load`=0, `ex_branch`=BRANCH_NONE, all other `ex_*` = 0.
- Capture: all `ex_*` <= bundle, `ex_valid` <= `id_valid`. Latency 1 cycle.
- Hazard terms, combinational, all require `id_valid`=1 and exclude register x0:
  - `lu` = `ex_valid` & `ex_mem_load` & `ex_reg_wnum`!=0 & (`reg_anum`==`ex_reg_wnum` | `reg_bnum`==`ex_reg_wnum`).
  - `jh` = `pcg_isjalr` & `ex_valid` & `ex_reg_wr` & `ex_reg_wnum`!=0 & `reg_anum`==`ex_reg_wnum`.
  - `jl` = `jh` & `ex_mem_load`.
  - Rationale: JALR rs1 is bypassed to PC gen from MEM (ALU result) or WB (load data).
- FSM states:
  - RUN: normal operation.
  - JWAIT: one extra JALR bubble owed.
- Per-cycle priority, highest first:
  1. `rst`.
  2. `mem_stall`=1: all registers and FSM hold, `stall_id`=1, no bubble, no count; `ex_redirect` is ignored (EX keeps it asserted).
  3. `ex_redirect`=1: write bubble, FSM -> RUN, `stall_id`=0, no count.
  4. FSM=JWAIT: write bubble, `stall_id`=1, `bubble_cnt`+1, FSM -> RUN.
  5. RUN with `lu` | `jh`: write bubble, `stall_id`=1, `bubble_cnt`+1; FSM -> JWAIT if `jl`, else stays RUN.
  6. Otherwise: capture, `stall_id`=0.
- Load-use costs exactly 1 bubble. JALR costs 1 bubble for an ALU producer and 2 for a load producer.
- `id_valid`=0: no hazard; an invalid slot is captured as `ex_valid`=0 and its fields are still registered.
- `bubble_cnt` wraps from 2^XLEN-1 to 0 silently.

Test Plan:
- Reset mid-stream, with JWAIT pending -> next cycle `ex_valid`=0, `bubble_cnt`=0, FSM=RUN, `stall_id`=0.
- `lw x5` in EX; ID has `add x6,x5,x1` with `id_valid`=1 -> `stall_id`=1 for 1 cycle, one bubble, `bubble_cnt`=1; add reaches EX on the following edge with `ex_reg_anum`=5.
- `addi x7` in EX; ID has `jalr x0,0(x7)` -> 1 bubble. With `lw x7` in EX instead -> 2 consecutive bubbles, `stall_id`=1 for 2 cycles, `bubble_cnt` +2.
- Load-use condition plus `mem_stall`=1 for 3 cycles -> `ex_*` frozen and `stall_id`=1 for 3 cycles with no count; then 1 bubble, `bubble_cnt`=1.
- FSM=JWAIT and `ex_redirect`=1 -> bubble written, FSM=RUN, `stall_id`=0, count unchanged. `lw x0` followed by a use of x0 -> no stall.
- Back-to-back independent instructions at pc 0x100, 0x104, 0x108 -> `ex_pc` follows one cycle later, `stall_id` stays 0. Preload `bubble_cnt`=0xFFFFFFFF and force a bubble -> `bubble_cnt`=0.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// Decoded ID -> EX bundle. The ID stage drives through 'out', the ID/EX register samples through 'in'.
interface if_id_ex #(
    parameter int XLEN = 32
);
    logic [1:0]      alu_sela;
    logic [1:0]      alu_selb;
    logic [2:0]      mem_opt;
    logic            mem_signed;
    logic            reg_wr;
    logic [4:0]      reg_anum;
    logic [4:0]      reg_bnum;
    logic [4:0]      reg_wnum;
    logic            mem_load;
    logic [2:0]      ALUctr;
    logic            ALUext;
    logic            mem_wr;
    logic [XLEN-1:0] imm;
    logic [2:0]      branch;
    logic [XLEN-1:0] pc;

    modport out (
        output alu_sela, alu_selb, mem_opt, mem_signed, reg_wr, reg_anum, reg_bnum,
               reg_wnum, mem_load, ALUctr, ALUext, mem_wr, imm, branch, pc
    );

    modport in (
        input  alu_sela, alu_selb, mem_opt, mem_signed, reg_wr, reg_anum, reg_bnum,
               reg_wnum, mem_load, ALUctr, ALUext, mem_wr, imm, branch, pc
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the decoded bundle, inserts load-use and JALR-source bubbles,
// honours downstream freeze and EX redirect, and counts inserted bubbles.
//
// state | meaning
// RUN   | normal operation
// JWAIT | one extra JALR bubble owed (rs1 producer is a load)
module id_ex_reg #(
    parameter int          XLEN        = 32,
    parameter logic [2:0]  BRANCH_NONE = 3'd0
) (
    input  logic            clk,
    input  logic            rst,
    if_id_ex.in             if_id_ex_ex,
    input  logic            id_valid,
    input  logic            pcg_isjalr,
    input  logic            mem_stall,
    input  logic            ex_redirect,
    output logic            ex_valid,
    output logic [1:0]      ex_alu_sela,
    output logic [1:0]      ex_alu_selb,
    output logic [2:0]      ex_mem_opt,
    output logic            ex_mem_signed,
    output logic            ex_reg_wr,
    output logic [4:0]      ex_reg_anum,
    output logic [4:0]      ex_reg_bnum,
    output logic [4:0]      ex_reg_wnum,
    output logic            ex_mem_load,
    output logic [2:0]      ex_ALUctr,
    output logic            ex_ALUext,
    output logic            ex_mem_wr,
    output logic [XLEN-1:0] ex_imm,
    output logic [2:0]      ex_branch,
    output logic [XLEN-1:0] ex_pc,
    output logic            stall_id,
    output logic [XLEN-1:0] bubble_cnt
);
    typedef struct packed {
        logic [1:0]      alu_sela;
        logic [1:0]      alu_selb;
        logic [2:0]      mem_opt;
        logic            mem_signed;
        logic            reg_wr;
        logic [4:0]      reg_anum;
        logic [4:0]      reg_bnum;
        logic [4:0]      reg_wnum;
        logic            mem_load;
        logic [2:0]      ALUctr;
        logic            ALUext;
        logic            mem_wr;
        logic [XLEN-1:0] imm;
        logic [2:0]      branch;
        logic [XLEN-1:0] pc;
    } bundle_t;

    typedef enum logic {RUN, JWAIT} state_t;

    bundle_t         id_b;
    bundle_t         bubble_b;
    bundle_t         ex_q;
    logic            valid_q;
    state_t          state_q;
    logic [XLEN-1:0] cnt_q;
    logic            wnum_nz;
    logic            lu;
    logic            jh;
    logic            jl;

    always_comb begin
        id_b            = '0;
        id_b.alu_sela   = if_id_ex_ex.alu_sela;
        id_b.alu_selb   = if_id_ex_ex.alu_selb;
        id_b.mem_opt    = if_id_ex_ex.mem_opt;
        id_b.mem_signed = if_id_ex_ex.mem_signed;
        id_b.reg_wr     = if_id_ex_ex.reg_wr;
        id_b.reg_anum   = if_id_ex_ex.reg_anum;
        id_b.reg_bnum   = if_id_ex_ex.reg_bnum;
        id_b.reg_wnum   = if_id_ex_ex.reg_wnum;
        id_b.mem_load   = if_id_ex_ex.mem_load;
        id_b.ALUctr     = if_id_ex_ex.ALUctr;
        id_b.ALUext     = if_id_ex_ex.ALUext;
        id_b.mem_wr     = if_id_ex_ex.mem_wr;
        id_b.imm        = if_id_ex_ex.imm;
        id_b.branch     = if_id_ex_ex.branch;
        id_b.pc         = if_id_ex_ex.pc;
    end

    always_comb begin
        bubble_b        = '0;
        bubble_b.branch = BRANCH_NONE;
    end

    // JALR rs1 is bypassed to PC gen from MEM (ALU result) or WB (load data), so an ALU producer
    // costs one bubble and a load producer two.
    assign wnum_nz = (ex_q.reg_wnum != 5'd0);
    assign lu = id_valid & valid_q & ex_q.mem_load & wnum_nz &
                ((id_b.reg_anum == ex_q.reg_wnum) | (id_b.reg_bnum == ex_q.reg_wnum));
    assign jh = id_valid & pcg_isjalr & valid_q & ex_q.reg_wr & wnum_nz &
                (id_b.reg_anum == ex_q.reg_wnum);
    assign jl = jh & ex_q.mem_load;

    assign stall_id = ~rst & (mem_stall | (~ex_redirect & ((state_q == JWAIT) | lu | jh)));

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= bubble_b;
            valid_q <= 1'b0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (mem_stall) begin
            // EX keeps ex_redirect asserted across the freeze, so it is acted on afterwards
            ex_q    <= ex_q;
        end else if (ex_redirect) begin
            ex_q    <= bubble_b;
            valid_q <= 1'b0;
            state_q <= RUN;
        end else if (state_q == JWAIT) begin
            ex_q    <= bubble_b;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + XLEN'(1);
            state_q <= RUN;
        end else if (lu | jh) begin
            ex_q    <= bubble_b;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + XLEN'(1);
            state_q <= jl ? JWAIT : RUN;
        end else begin
            ex_q    <= id_b;
            valid_q <= id_valid;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_sela   = ex_q.alu_sela;
    assign ex_alu_selb   = ex_q.alu_selb;
    assign ex_mem_opt    = ex_q.mem_opt;
    assign ex_mem_signed = ex_q.mem_signed;
    assign ex_reg_wr     = ex_q.reg_wr;
    assign ex_reg_anum   = ex_q.reg_anum;
    assign ex_reg_bnum   = ex_q.reg_bnum;
    assign ex_reg_wnum   = ex_q.reg_wnum;
    assign ex_mem_load   = ex_q.mem_load;
    assign ex_ALUctr     = ex_q.ALUctr;
    assign ex_ALUext     = ex_q.ALUext;
    assign ex_mem_wr     = ex_q.mem_wr;
    assign ex_imm        = ex_q.imm;
    assign ex_branch     = ex_q.branch;
    assign ex_pc         = ex_q.pc;
    assign bubble_cnt    = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed-vector bench for id_ex_reg: a table of per-cycle ID inputs with hand-computed EX outputs,
// plus hand sequences for reset with a JALR bubble owed and counter wrap on a narrow instance.
module tb_id_ex_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic id_valid = 1'b0, pcg_isjalr = 1'b0, mem_stall = 1'b0, ex_redirect = 1'b0;
    logic        ex_valid, ex_mem_signed, ex_reg_wr, ex_mem_load, ex_ALUext, ex_mem_wr, stall_id;
    logic [1:0]  ex_alu_sela, ex_alu_selb;
    logic [2:0]  ex_mem_opt, ex_ALUctr, ex_branch;
    logic [4:0]  ex_reg_anum, ex_reg_bnum, ex_reg_wnum;
    logic [31:0] ex_imm, ex_pc, bubble_cnt;

    if_id_ex #(.XLEN(32)) bus ();

    id_ex_reg #(.XLEN(32), .BRANCH_NONE(3'd0)) dut (
        .clk(clk), .rst(rst), .if_id_ex_ex(bus),
        .id_valid(id_valid), .pcg_isjalr(pcg_isjalr), .mem_stall(mem_stall), .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_alu_sela(ex_alu_sela), .ex_alu_selb(ex_alu_selb), .ex_mem_opt(ex_mem_opt),
        .ex_mem_signed(ex_mem_signed), .ex_reg_wr(ex_reg_wr), .ex_reg_anum(ex_reg_anum),
        .ex_reg_bnum(ex_reg_bnum), .ex_reg_wnum(ex_reg_wnum), .ex_mem_load(ex_mem_load),
        .ex_ALUctr(ex_ALUctr), .ex_ALUext(ex_ALUext), .ex_mem_wr(ex_mem_wr), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .stall_id(stall_id), .bubble_cnt(bubble_cnt)
    );

    // Narrow instance so the counter wrap is reachable in a few dozen cycles.
    logic s_valid = 1'b0;
    logic       s_ex_valid, s_ex_mem_signed, s_ex_reg_wr, s_ex_mem_load, s_ex_ALUext, s_ex_mem_wr, s_stall;
    logic [1:0] s_ex_alu_sela, s_ex_alu_selb;
    logic [2:0] s_ex_mem_opt, s_ex_ALUctr, s_ex_branch;
    logic [4:0] s_ex_reg_anum, s_ex_reg_bnum, s_ex_reg_wnum;
    logic [3:0] s_ex_imm, s_ex_pc, s_cnt;

    if_id_ex #(.XLEN(4)) sbus ();

    id_ex_reg #(.XLEN(4), .BRANCH_NONE(3'd0)) sdut (
        .clk(clk), .rst(rst), .if_id_ex_ex(sbus),
        .id_valid(s_valid), .pcg_isjalr(1'b0), .mem_stall(1'b0), .ex_redirect(1'b0),
        .ex_valid(s_ex_valid), .ex_alu_sela(s_ex_alu_sela), .ex_alu_selb(s_ex_alu_selb),
        .ex_mem_opt(s_ex_mem_opt), .ex_mem_signed(s_ex_mem_signed), .ex_reg_wr(s_ex_reg_wr),
        .ex_reg_anum(s_ex_reg_anum), .ex_reg_bnum(s_ex_reg_bnum), .ex_reg_wnum(s_ex_reg_wnum),
        .ex_mem_load(s_ex_mem_load), .ex_ALUctr(s_ex_ALUctr), .ex_ALUext(s_ex_ALUext),
        .ex_mem_wr(s_ex_mem_wr), .ex_imm(s_ex_imm), .ex_branch(s_ex_branch), .ex_pc(s_ex_pc),
        .stall_id(s_stall), .bubble_cnt(s_cnt)
    );

    typedef struct {
        logic        vld, jalr, mst, rdr;
        logic [4:0]  ra, rb, rw;
        logic        wr, ld;
        logic [2:0]  br;
        logic [31:0] pc;
        logic        e_stall, e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_ra, e_rw;
        logic [2:0]  e_br;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   vectors    = 0;
    int   miscompares = 0;

    function automatic vec_t mk(int vld, int jalr, int mst, int rdr, int ra, int rb, int rw, int wr,
                                int ld, int br, int pc, int e_stall, int e_valid, int e_pc,
                                int e_ra, int e_rw, int e_br, int e_cnt);
        vec_t v;
        v.vld = 1'(vld);   v.jalr = 1'(jalr); v.mst = 1'(mst); v.rdr = 1'(rdr);
        v.ra = 5'(ra);     v.rb = 5'(rb);     v.rw = 5'(rw);
        v.wr = 1'(wr);     v.ld = 1'(ld);     v.br = 3'(br);   v.pc = 32'(pc);
        v.e_stall = 1'(e_stall); v.e_valid = 1'(e_valid); v.e_pc = 32'(e_pc);
        v.e_ra = 5'(e_ra); v.e_rw = 5'(e_rw); v.e_br = 3'(e_br); v.e_cnt = 32'(e_cnt);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.vld; pcg_isjalr = v.jalr; mem_stall = v.mst; ex_redirect = v.rdr;
        bus.reg_anum = v.ra; bus.reg_bnum = v.rb; bus.reg_wnum = v.rw;
        bus.reg_wr = v.wr;   bus.mem_load = v.ld; bus.branch = v.br; bus.pc = v.pc;
        bus.imm = ~v.pc;     bus.mem_wr = v.pc[3]; bus.mem_opt = v.pc[6:4];
        bus.ALUctr = v.pc[2:0]; bus.ALUext = v.pc[2]; bus.mem_signed = v.pc[4];
        bus.alu_sela = v.pc[3:2]; bus.alu_selb = v.pc[5:4];
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " stall_id"}, 32'(stall_id), 32'(v.e_stall));
        @(posedge clk);
        #1;
        vectors++;
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'(v.e_valid));
        chk({tag, " ex_pc"}, ex_pc, v.e_pc);
        chk({tag, " ex_reg_anum"}, 32'(ex_reg_anum), 32'(v.e_ra));
        chk({tag, " ex_reg_wnum"}, 32'(ex_reg_wnum), 32'(v.e_rw));
        chk({tag, " ex_branch"}, 32'(ex_branch), 32'(v.e_br));
        chk({tag, " bubble_cnt"}, bubble_cnt, v.e_cnt);
        if (v.e_pc == 32'h0)
            chk({tag, " bubble ctl"}, {ex_imm[27:0], ex_reg_wr, ex_mem_wr, ex_mem_load, ex_mem_signed}, 32'h0);
        else
            chk({tag, " ex_imm"}, ex_imm, ~v.e_pc);
    endtask

    initial begin
        vec_t z;
        // --- vectors: {vld,jalr,mst,rdr, ra,rb,rw,wr,ld,br,pc | stall,valid,pc,ra,rw,br,cnt}
        tbl.push_back(mk(1,0,0,0,  2,3, 1,1,0,0,'h100, 0,1,'h100, 2, 1,0,0)); // 0 independent stream
        tbl.push_back(mk(1,0,0,0,  1,1, 4,1,0,0,'h104, 0,1,'h104, 1, 4,0,0));
        tbl.push_back(mk(1,0,0,0,  4,0, 6,1,0,0,'h108, 0,1,'h108, 4, 6,0,0));
        tbl.push_back(mk(1,0,0,0,  2,0, 5,1,1,0,'h10C, 0,1,'h10C, 2, 5,0,0)); // lw x5
        tbl.push_back(mk(1,0,0,0,  5,1, 6,1,0,0,'h110, 1,0,0,     0, 0,0,1)); // add x6,x5,x1: bubble
        tbl.push_back(mk(1,0,0,0,  5,1, 6,1,0,0,'h110, 0,1,'h110, 5, 6,0,1));
        tbl.push_back(mk(1,0,0,0,  0,0, 7,1,0,0,'h114, 0,1,'h114, 0, 7,0,1)); // addi x7
        tbl.push_back(mk(1,1,0,0,  7,0, 0,1,0,5,'h118, 1,0,0,     0, 0,0,2)); // jalr after ALU: 1 bubble
        tbl.push_back(mk(1,1,0,0,  7,0, 0,1,0,5,'h118, 0,1,'h118, 7, 0,5,2));
        tbl.push_back(mk(1,0,0,0,  2,0, 7,1,1,0,'h11C, 0,1,'h11C, 2, 7,0,2)); // lw x7
        tbl.push_back(mk(1,1,0,0,  7,0, 0,1,0,5,'h120, 1,0,0,     0, 0,0,3)); // jalr after load: 2 bubbles
        tbl.push_back(mk(1,1,0,0,  7,0, 0,1,0,5,'h120, 1,0,0,     0, 0,0,4));
        tbl.push_back(mk(1,1,0,0,  7,0, 0,1,0,5,'h120, 0,1,'h120, 7, 0,5,4));
        tbl.push_back(mk(1,0,0,0,  2,0, 0,1,1,0,'h124, 0,1,'h124, 2, 0,0,4)); // lw x0
        tbl.push_back(mk(1,0,0,0,  0,0, 8,1,0,0,'h128, 0,1,'h128, 0, 8,0,4)); // use of x0: no stall
        tbl.push_back(mk(1,0,0,0,  2,0, 9,1,1,0,'h12C, 0,1,'h12C, 2, 9,0,4)); // lw x9
        tbl.push_back(mk(1,0,1,0,  9,0,10,1,0,0,'h130, 1,1,'h12C, 2, 9,0,4)); // freeze x3
        tbl.push_back(mk(1,0,1,0,  9,0,10,1,0,0,'h130, 1,1,'h12C, 2, 9,0,4));
        tbl.push_back(mk(1,0,1,0,  9,0,10,1,0,0,'h130, 1,1,'h12C, 2, 9,0,4));
        tbl.push_back(mk(1,0,0,0,  9,0,10,1,0,0,'h130, 1,0,0,     0, 0,0,5));
        tbl.push_back(mk(1,0,0,0,  9,0,10,1,0,0,'h130, 0,1,'h130, 9,10,0,5));
        tbl.push_back(mk(0,0,0,0,  3,0,11,1,0,0,'h134, 0,0,'h134, 3,11,0,5)); // invalid slot registered
        tbl.push_back(mk(1,0,0,0,  2,0,12,1,1,0,'h138, 0,1,'h138, 2,12,0,5)); // lw x12
        tbl.push_back(mk(0,0,0,0, 12,0,13,1,0,0,'h13C, 0,0,'h13C,12,13,0,5)); // invalid user: no hazard
        tbl.push_back(mk(1,0,0,0,  2,0,14,1,1,0,'h140, 0,1,'h140, 2,14,0,5)); // lw x14
        tbl.push_back(mk(1,0,0,1, 14,0,15,1,0,0,'h144, 0,0,0,     0, 0,0,5)); // redirect beats load-use
        tbl.push_back(mk(1,0,0,0,  2,0, 7,1,1,0,'h150, 0,1,'h150, 2, 7,0,5)); // lw x7
        tbl.push_back(mk(1,1,0,0,  7,0, 0,1,0,5,'h154, 1,0,0,     0, 0,0,6)); // -> JWAIT
        tbl.push_back(mk(1,1,0,1,  7,0, 0,1,0,5,'h154, 0,0,0,     0, 0,0,6)); // redirect clears JWAIT
        tbl.push_back(mk(1,0,0,0,  1,0, 3,1,0,0,'h200, 0,1,'h200, 1, 3,0,6)); // back in RUN

        z = mk(0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        drive(z);
        sbus.alu_sela = '0; sbus.alu_selb = '0; sbus.mem_opt = '0; sbus.mem_signed = 1'b0;
        sbus.reg_wr = 1'b0; sbus.reg_anum = '0; sbus.reg_bnum = '0; sbus.reg_wnum = '0;
        sbus.mem_load = 1'b0; sbus.ALUctr = '0; sbus.ALUext = 1'b0; sbus.mem_wr = 1'b0;
        sbus.imm = 4'hF; sbus.branch = 3'd3; sbus.pc = 4'h4;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        chk("reset ex_valid", 32'(ex_valid), 32'h0);
        chk("reset bubble_cnt", bubble_cnt, 32'h0);
        chk("reset ex_branch", 32'(ex_branch), 32'h0);
        chk("reset stall_id", 32'(stall_id), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

        // Reset while a second JALR bubble is owed.
        run_vec(mk(1,0,0,0, 2,0,7,1,1,0,'h160, 0,1,'h160, 2,7,0,6), "rs lw");
        run_vec(mk(1,1,0,0, 7,0,0,1,0,5,'h164, 1,0,0,     0,0,0,7), "rs jalr");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs stall in reset", 32'(stall_id), 32'h0);
        @(posedge clk);
        #1;
        vectors++;
        chk("rs ex_valid", 32'(ex_valid), 32'h0);
        chk("rs ex_pc", ex_pc, 32'h0);
        chk("rs bubble_cnt", bubble_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(1,1,0,0, 7,0,0,1,0,5,'h164, 0,1,'h164, 7,0,5,0), "rs run");

        // Counter wrap on the 4-bit instance: 16 load-use bubbles bring it back to zero.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            s_valid = 1'b1; sbus.mem_load = 1'b1; sbus.reg_wr = 1'b1; sbus.reg_wnum = 5'd5; sbus.reg_anum = 5'd2;
            @(negedge clk);
            sbus.mem_load = 1'b0; sbus.reg_wnum = 5'd6; sbus.reg_anum = 5'd5;
            #1;
            if (k == 16) chk("wrap stall", 32'(s_stall), 32'h1);
            @(posedge clk);
            #1;
            if (k == 15) begin
                vectors++;
                chk("wrap cnt 15", 32'(s_cnt), 32'hF);
            end
            if (k == 16) begin
                vectors++;
                chk("wrap cnt 0", 32'(s_cnt), 32'h0);
                chk("wrap bubble valid", 32'(s_ex_valid), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
